// File: rtl/gravel_sensor_pkg.sv
// Definitions shared between the intersection controller and the gravel-road sensor block.
package gravel_sensor_pkg;

  localparam int unsigned STATE_W  = 2;
  localparam int unsigned LAMP_W   = 3;
  localparam int unsigned DB_CNT_W = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'b00,
    REQUEST = 2'b01,
    SERVE   = 2'b10,
    DRAIN   = 2'b11
  } state_e;

  localparam logic [LAMP_W-1:0] LAMP_RED = 3'b100;
  localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
  localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b001;

  // A lamp code is legal only when exactly one lamp is lit.
  function automatic logic lamp_legal(input logic [LAMP_W-1:0] g);
    return (g == LAMP_RED) || (g == LAMP_YEL) || (g == LAMP_GRN);
  endfunction

endpackage

// File: rtl/gravel_sensor_debounce.sv
// Loop-detector conditioning: 2-flop synchronizer, stability counter, and arrival pulse.
module sensor_debounce
  import gravel_sensor_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sensor_i,
  output logic arrival_c
);

  logic                sync1_q, sync2_q;
  logic                level_q, level_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;
  logic                mismatch;
  logic                expire;

  assign mismatch = sync2_q ^ level_q;
  assign expire   = mismatch && (cnt_q == DB_CNT_W'(DEBOUNCE - 1));

  // The arrival is flagged in the cycle whose closing edge raises the level.
  assign arrival_c = expire & sync2_q;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (expire) begin
      level_d = sync2_q;
    end else if (mismatch) begin
      cnt_d = cnt_q + DB_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sensor_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/gravel_sensor.sv
// Gravel-road vehicle sensor: counts debounced arrivals and requests service from the
// intersection controller through a four-state handshake on the gravel lamp code.
module gravel_sensor
  import gravel_sensor_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              SENSOR,
  input  logic [LAMP_W-1:0] Gravel,
  output logic              TRAFFIC,
  output logic [CNT_W-1:0]  Waiting,
  output logic [STATE_W-1:0] State,
  output logic              Fault
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   waiting_q, waiting_d;
  logic               traffic_q, traffic_d;
  logic               fault_q, fault_d;
  logic               arrival;

  sensor_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk       (clock),
    .rst_n     (reset),
    .sensor_i  (SENSOR),
    .arrival_c (arrival)
  );

  always_comb begin
    state_d   = state_q;
    waiting_d = waiting_q;
    traffic_d = 1'b0;
    fault_d   = fault_q | ~lamp_legal(Gravel);

    case (state_q)
      IDLE:    if (arrival) state_d = REQUEST;
      REQUEST: if (Gravel == LAMP_GRN) state_d = SERVE;
      SERVE:   if ((Gravel == LAMP_YEL) || (Gravel == LAMP_RED)) state_d = DRAIN;
      // A coincident arrival counts as waiting so the request is not lost in IDLE.
      DRAIN:   if (Gravel == LAMP_RED)
                 state_d = ((waiting_q != '0) || arrival) ? REQUEST : IDLE;
      default: state_d = IDLE;
    endcase

    // Entering SERVE clears the count; an arrival in that same clock still counts.
    if ((state_q != SERVE) && (state_d == SERVE)) begin
      waiting_d = arrival ? CNT_W'(1) : '0;
    end else if (arrival && (waiting_q != '1)) begin
      waiting_d = waiting_q + CNT_W'(1);
    end

    traffic_d = (state_d == REQUEST);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      waiting_q <= '0;
      traffic_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      waiting_q <= waiting_d;
      traffic_q <= traffic_d;
      fault_q   <= fault_d;
    end
  end

  assign TRAFFIC = traffic_q;
  assign Waiting = waiting_q;
  assign State   = state_q;
  assign Fault   = fault_q;

endmodule

// File: tb/tb_gravel_sensor.sv
// Directed and randomized bench for gravel_sensor against a behavioural reference model.
module tb_gravel_sensor;

  localparam int DB   = 4;
  localparam int WMAX = 15;

  logic       clock  = 1'b0;
  logic       reset  = 1'b0;
  logic       SENSOR = 1'b0;
  logic [2:0] Gravel = 3'b100;
  logic       TRAFFIC;
  logic [3:0] Waiting;
  logic [1:0] State;
  logic       Fault;

  always #5 clock = ~clock;

  gravel_sensor #(.DEBOUNCE(DB), .CNT_W(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .SENSOR  (SENSOR),
    .Gravel  (Gravel),
    .TRAFFIC (TRAFFIC),
    .Waiting (Waiting),
    .State   (State),
    .Fault   (Fault)
  );

  int n_pass   = 0;
  int n_fail   = 0;
  int n_checks = 0;

  // Reference model: sample delay line, run length of disagreeing samples, plain counters.
  bit m_pipe[$];
  bit m_deb;
  int m_run;
  int m_state;
  int m_wait;
  bit m_fault;
  bit m_traffic;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pipe    = '{1'b0, 1'b0};
    m_deb     = 1'b0;
    m_run     = 0;
    m_state   = 0;
    m_wait    = 0;
    m_fault   = 1'b0;
    m_traffic = 1'b0;
  endtask

  task automatic model_step();
    bit s;
    bit arr;
    int nxt;
    s = m_pipe.pop_front();
    m_pipe.push_back(SENSOR);
    arr = 1'b0;
    if (s != m_deb) begin
      m_run++;
      if (m_run == DB) begin
        m_deb = s;
        m_run = 0;
        arr   = s;
      end
    end else begin
      m_run = 0;
    end
    if ($countones(Gravel) != 1) m_fault = 1'b1;
    nxt = m_state;
    case (m_state)
      0: if (arr) nxt = 1;
      1: if (Gravel == 3'b001) nxt = 2;
      2: if (Gravel == 3'b010 || Gravel == 3'b100) nxt = 3;
      default: if (Gravel == 3'b100) nxt = (m_wait != 0 || arr) ? 1 : 0;
    endcase
    if (m_state != 2 && nxt == 2) m_wait = arr ? 1 : 0;
    else if (arr && m_wait < WMAX) m_wait++;
    m_state   = nxt;
    m_traffic = (m_state == 1);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    chk("traffic", int'(TRAFFIC), int'(m_traffic));
    chk("waiting", int'(Waiting), m_wait);
    chk("state",   int'(State),   m_state);
    chk("fault",   int'(Fault),   int'(m_fault));
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    chk("rst_traffic", int'(TRAFFIC), 0);
    chk("rst_waiting", int'(Waiting), 0);
    chk("rst_state",   int'(State),   0);
    chk("rst_fault",   int'(Fault),   0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic arrive();
    SENSOR = 1'b1;
    tick_n(8);
    SENSOR = 1'b0;
    tick_n(8);
  endtask

  initial begin
    int lat;
    int hold;
    int r;

    // Power-on reset
    model_reset();
    #1;
    chk("por_state", int'(State), 0);
    chk("por_traffic", int'(TRAFFIC), 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    tick_n(3);

    // Clean arrival under red: request within 7 clocks of the sensor edge
    Gravel = 3'b100;
    SENSOR = 1'b1;
    lat = 0;
    while (TRAFFIC !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    chk("traffic_latency_le7", int'(lat <= 7), 1);
    tick_n(20 - lat);
    chk("req_state", int'(State), 1);
    chk("req_waiting", int'(Waiting), 1);

    // Full service cycle
    SENSOR = 1'b0;
    tick_n(8);
    Gravel = 3'b001;
    tick();
    chk("serve_state", int'(State), 2);
    chk("serve_traffic", int'(TRAFFIC), 0);
    chk("serve_waiting", int'(Waiting), 0);
    Gravel = 3'b010;
    tick();
    chk("drain_state", int'(State), 3);
    Gravel = 3'b100;
    tick();
    chk("idle_state", int'(State), 0);

    // Bouncing sensor never produces an arrival
    for (int i = 0; i < 15; i++) begin
      SENSOR = (i % 2 == 0);
      tick_n(2);
    end
    SENSOR = 1'b0;
    tick_n(8);
    chk("bounce_waiting", int'(Waiting), 0);
    chk("bounce_traffic", int'(TRAFFIC), 0);
    chk("bounce_state", int'(State), 0);

    // Arrivals during SERVE re-request after drain
    arrive();
    Gravel = 3'b001;
    tick();
    arrive();
    arrive();
    chk("serve_hold_traffic", int'(TRAFFIC), 0);
    Gravel = 3'b010;
    tick();
    Gravel = 3'b100;
    tick();
    chk("rereq_state", int'(State), 1);
    chk("rereq_traffic", int'(TRAFFIC), 1);
    chk("rereq_waiting", int'(Waiting), 2);

    // Saturation
    for (int i = 0; i < 20; i++) arrive();
    chk("sat_waiting", int'(Waiting), 15);
    tick_n(5);
    chk("sat_hold", int'(Waiting), 15);

    // Arrival coincident with green
    SENSOR = 1'b1;
    tick_n(5);
    Gravel = 3'b001;
    tick();
    chk("coinc_state", int'(State), 2);
    chk("coinc_waiting", int'(Waiting), 1);
    SENSOR = 1'b0;
    tick_n(8);

    // Illegal lamp code, sticky fault, async reset mid-REQUEST
    Gravel = 3'b010;
    tick();
    Gravel = 3'b100;
    tick();
    chk("pre_fault_state", int'(State), 1);
    Gravel = 3'b011;
    tick();
    chk("fault_set", int'(Fault), 1);
    chk("fault_hold_state", int'(State), 1);
    Gravel = 3'b100;
    tick_n(3);
    chk("fault_sticky", int'(Fault), 1);
    chk("pre_rst_traffic", int'(TRAFFIC), 1);
    apply_reset();
    tick_n(4);

    // Randomized traffic with a mid-run reset
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        SENSOR = 1'($urandom_range(0, 1));
        hold   = $urandom_range(1, 12);
      end
      hold--;
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 15);
        if (r < 5)       Gravel = 3'b100;
        else if (r < 9)  Gravel = 3'b010;
        else if (r < 15) Gravel = 3'b001;
        else             Gravel = 3'($urandom_range(0, 7));
      end
      if (i == 1500) apply_reset();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gravel_sensor.md
GRAVEL_SENSOR -- requirements
Module: gravel_sensor

Interface
REQ-001 Parameter: DEBOUNCE, 4, consecutive clocks a synchronized sensor level must hold before it is accepted (legal range 1..15).
REQ-002 Parameter: CNT_W, 4, width of the waiting-vehicle counter.
REQ-003 Port: clock  input  1  single system clock; all state changes on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: SENSOR  input  1  raw, asynchronous, bouncing gravel-road loop detector (1 = vehicle present).
REQ-006 Port: Gravel  input  3  gravel lamp code from the intersection controller, one-hot: [2] red, [1] yellow, [0] green.
REQ-007 Port: TRAFFIC  output  1  registered service request to the controller's TRAFFIC input.
REQ-008 Port: Waiting  output  CNT_W  registered count of vehicles arrived and not yet served.
REQ-009 Port: State  output  2  current FSM state encoding.
REQ-010 Port: Fault  output  1  sticky flag: illegal Gravel code seen.

Function
REQ-011 SENSOR passes a 2-flop synchronizer; the debounced level changes only after the synchronized value differs from it for DEBOUNCE consecutive clocks; any mismatch-free sample resets the stability counter.
REQ-012 An arrival is a single-cycle pulse on each 0->1 transition of the debounced level; 1->0 transitions produce nothing.
REQ-013 Waiting increments on each arrival, saturates at all-ones, never wraps.
REQ-014 FSM states: IDLE=00, REQUEST=01, SERVE=10, DRAIN=11.
REQ-015 IDLE: TRAFFIC=0; on arrival -> REQUEST.
REQ-016 REQUEST: TRAFFIC=1; stays until Gravel==001 (green), then -> SERVE.
REQ-017 Entry to SERVE clears Waiting to 0; an arrival in the same clock as the clear leaves Waiting=1 (arrival wins over clear).
REQ-018 SERVE: TRAFFIC=0; on Gravel==010 (yellow) or 100 (red) -> DRAIN.
REQ-019 DRAIN: TRAFFIC=0; on Gravel==100 -> REQUEST if Waiting!=0, else IDLE.
REQ-020 Arrivals in SERVE and DRAIN increment Waiting but never assert TRAFFIC before DRAIN exits.
REQ-021 TRAFFIC is a registered decode of the next state; it rises on the clock edge that enters REQUEST.
REQ-022 A Gravel value not exactly one-hot, sampled on any clock, sets Fault=1 until reset; the FSM treats the illegal value as no match and holds state.
REQ-023 Gravel is synchronous to clock; no synchronizer on Gravel.

Reset
REQ-024 reset low asynchronously forces State=IDLE, TRAFFIC=0, Waiting=0, Fault=0, debounced level=0, stability counter=0, synchronizer flops=0.
REQ-025 Reset asserted mid-REQUEST or mid-SERVE drops TRAFFIC immediately and discards Waiting; after release the block starts in IDLE and needs a fresh debounced arrival.
REQ-026 First state change after reset release occurs no earlier than the second rising clock edge.

Structure
REQ-027 Shared package holds FSM state constants (IDLE, REQUEST, SERVE, DRAIN) and lamp code constants LAMP_RED=100, LAMP_YEL=010, LAMP_GRN=001, common to the intersection controller and this block.
REQ-028 One sub-module, sensor_debounce (synchronizer + stability counter + arrival pulse), instantiated once; FSM and counter live in gravel_sensor.

Verification
REQ-029 IDLE, Gravel=100, SENSOR 0->1 held 20 clocks, DEBOUNCE=4 -> TRAFFIC rises within 7 clocks of the SENSOR edge, Waiting=1, State=01.
REQ-030 SENSOR toggled every 2 clocks for 30 clocks, DEBOUNCE=4 -> no arrival, Waiting=0, TRAFFIC=0.
REQ-031 Full cycle: arrival, Gravel 100->001 -> TRAFFIC falls next clock, State=10, Waiting=0; Gravel 010 -> State=11; Gravel 100 -> State=00.
REQ-032 Two arrivals during SERVE, Gravel returns 100 -> State=01, TRAFFIC=1, Waiting=2; 20 arrivals before green -> Waiting=15, holds at 15.
REQ-033 Gravel=011 for one clock in REQUEST -> Fault=1, State stays 01; Fault stays 1 after Gravel legal; reset low -> Fault=0, TRAFFIC=0, State=00 with no clock edge.
REQ-034 Arrival pulse coincident with Gravel 001 in REQUEST -> State=10, Waiting=1.
